// File: rtl/edge_map_packer.sv
// edge_map_packer: collects the serial inner-pixel edge bit stream, packs it
// LSB-first into WORD_W-bit words and hands them out through a small show-ahead
// FIFO with a valid/ready handshake. The final word of each frame is tagged.
module edge_map_packer #(
    parameter int IMG_DIM    = 20,
    parameter int WORD_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              edge_in,
    input  logic              edge_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              frame_done,
    output logic              overflow
);
    localparam int FRAME_BITS = (IMG_DIM - 2) * (IMG_DIM - 2);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int FILL_W     = $clog2(WORD_W);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [WORD_W-1:0] mem_word_q [FIFO_DEPTH];
    logic              mem_last_q [FIFO_DEPTH];

    logic              accept_bit;
    logic              push_req;
    logic              push_last;
    logic [WORD_W-1:0] push_word;
    logic              fifo_full;
    logic              head_last;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // Show-ahead head of the FIFO; outputs held at 0 while empty.
    always_comb begin
        word_valid = (count_q != '0);
        head_last  = mem_last_q[rd_ptr_q];
        word_out   = word_valid ? mem_word_q[rd_ptr_q] : '0;
        word_last  = word_valid & head_last;
        frame_done = frame_done_q;
        overflow   = overflow_q;
    end

    // Word completion and FIFO write/read decisions. A word that cannot be
    // written (full, no pop this cycle) is dropped but still counts as pushed.
    always_comb begin
        accept_bit            = (state_q == COLLECT) && edge_valid;
        push_last             = accept_bit && (bit_cnt_q == BIT_LAST);
        push_req              = accept_bit &&
                                ((fill_cnt_q == FILL_LAST) || (bit_cnt_q == BIT_LAST));
        push_word             = shift_reg_q;
        push_word[fill_cnt_q] = edge_in;
        fifo_full             = (count_q == CNT_FULL);
        pop                   = word_valid && word_ready;
        wr_en                 = push_req && (!fifo_full || pop);
        drop                  = push_req && !wr_en;
    end

    // Packer FSM next state: COLLECT packs bits, DRAIN waits for the tagged word to leave.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        shift_reg_d = shift_reg_q;
        case (state_q)
            COLLECT: begin
                if (edge_valid) begin
                    if (push_req) begin
                        shift_reg_d = '0;
                        fill_cnt_d  = '0;
                    end else begin
                        shift_reg_d = push_word;
                        fill_cnt_d  = fill_cnt_q + FILL_W'(1);
                    end
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        // A dropped tail word leaves nothing to wait for.
                        if (wr_en) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // FIFO bookkeeping, frame-done pulse and sticky overflow flag.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        frame_done_d = pop && head_last;
        overflow_d   = overflow_q | drop | ((state_q == DRAIN) && edge_valid);
    end

    // Control and packing state; reset discards any partial word and queued words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= COLLECT;
            bit_cnt_q    <= '0;
            fill_cnt_q   <= '0;
            shift_reg_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            shift_reg_q  <= shift_reg_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_word_q[wr_ptr_q] <= push_word;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end
endmodule

// File: tb/tb_edge_map_packer.sv
// Testbench for edge_map_packer: scoreboard of expected words built from the
// driven bit stream, compared as the DUT hands words out.
module tb_edge_map_packer;
    localparam int FB = 324;

    typedef struct packed {
        logic [17:0] w;
        logic        l;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        edge_in, edge_valid, word_ready;
    logic [17:0] word_out;
    logic        word_valid, word_last, frame_done, overflow;

    logic        edge_in2, edge_valid2, word_ready2;
    logic [15:0] word_out2;
    logic        word_valid2, word_last2, frame_done2, overflow2;

    int   checks = 0;
    int   errors = 0;
    int   got_cnt = 0;
    int   fd_cnt = 0;
    exp_t sb[$];
    logic fb [FB];

    edge_map_packer u_dut (
        .clk        (clk),
        .reset      (reset),
        .edge_in    (edge_in),
        .edge_valid (edge_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    edge_map_packer #(.WORD_W(16)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .edge_in    (edge_in2),
        .edge_valid (edge_valid2),
        .word_out   (word_out2),
        .word_valid (word_valid2),
        .word_ready (word_ready2),
        .word_last  (word_last2),
        .frame_done (frame_done2),
        .overflow   (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: compares each handed-out word and the frame_done pulse.
    initial begin
        exp_t e;
        logic fd_pend;
        fd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                fd_pend = 1'b0;
            end else begin
                if (fd_pend || frame_done) begin
                    checks++;
                    if (frame_done !== fd_pend) begin
                        errors++;
                        $display("FAIL frame_done_pulse: got %b, required %b", frame_done, fd_pend);
                    end
                end
                if (frame_done === 1'b1) fd_cnt++;
                fd_pend = 1'b0;
                if (word_valid === 1'b1 && word_ready === 1'b1) begin
                    got_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got %h last=%b, required no word", word_out, word_last);
                        fd_pend = word_last;
                    end else begin
                        e = sb.pop_front();
                        if (word_out !== e.w || word_last !== e.l) begin
                            errors++;
                            $display("FAIL word_compare: got %h last=%b, required %h last=%b",
                                     word_out, word_last, e.w, e.l);
                        end
                        fd_pend = e.l;
                    end
                end
            end
        end
    end

    // Drives nbits of fb[] and queues the words the packer should deliver.
    task automatic send_frame(input int nbits, input int keep, input int rdy_bit, input bit stall_end);
        logic [17:0] acc;
        int          fill;
        int          nw;
        exp_t        e;
        acc  = '0;
        fill = 0;
        nw   = 0;
        for (int k = 0; k < nbits; k++) begin
            acc[fill]  = fb[k];
            edge_in    = fb[k];
            edge_valid = 1'b1;
            word_ready = (k >= rdy_bit) && !(stall_end && k == FB - 1);
            if (fill == 17 || k == FB - 1) begin
                e.w = acc;
                e.l = (k == FB - 1);
                if (nw < keep) sb.push_back(e);
                nw++;
                acc  = '0;
                fill = 0;
            end else begin
                fill++;
            end
            @(posedge clk); #1;
        end
        edge_valid = 1'b0;
        edge_in    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        word_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (word_valid !== 1'b0 || word_last !== 1'b0 || frame_done !== 1'b0 ||
            overflow !== 1'b0 || word_out !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b done=%b ovf=%b word=%h, required all 0",
                     word_valid, word_last, frame_done, overflow, word_out);
        end
        checks++;
        if (word_valid2 !== 1'b0 || overflow2 !== 1'b0 || word_out2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs16: valid=%b ovf=%b word=%h, required all 0",
                     word_valid2, overflow2, word_out2);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %b, required 0", word_valid);
        end
    endtask

    task automatic test_alternating();
        int g0, f0;
        g0 = got_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < FB; k++) fb[k] = 1'(k % 2);
        send_frame(FB, 18, 0, 1'b0);
        wait_drain("t1");
        checks++;
        if ((got_cnt - g0) != 18) begin
            errors++;
            $display("FAIL t1_word_count: got %0d, required 18", got_cnt - g0);
        end
        checks++;
        if ((fd_cnt - f0) != 1) begin
            errors++;
            $display("FAIL t1_frame_done_count: got %0d, required 1", fd_cnt - f0);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL t1_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_word16();
        logic [16:0] got2[$];
        logic [16:0] e2;
        int          fd2;
        fd2         = 0;
        word_ready2 = 1'b1;
        fork
            begin
                for (int k = 0; k < FB; k++) begin
                    edge_in2    = 1'b1;
                    edge_valid2 = 1'b1;
                    @(posedge clk); #1;
                end
                edge_valid2 = 1'b0;
                edge_in2    = 1'b0;
            end
            begin
                repeat (FB + 20) begin
                    @(negedge clk);
                    if (word_valid2 === 1'b1 && word_ready2 === 1'b1) got2.push_back({word_last2, word_out2});
                    if (frame_done2 === 1'b1) fd2++;
                end
            end
        join
        checks++;
        if (got2.size() != 21) begin
            errors++;
            $display("FAIL t2_word_count: got %0d, required 21", got2.size());
        end
        for (int i = 0; i < got2.size() && i < 21; i++) begin
            e2 = (i == 20) ? {1'b1, 16'h000F} : {1'b0, 16'hFFFF};
            checks++;
            if (got2[i] !== e2) begin
                errors++;
                $display("FAIL t2_word%0d: got last=%b %h, required last=%b %h",
                         i, got2[i][16], got2[i][15:0], e2[16], e2[15:0]);
            end
        end
        checks++;
        if (fd2 != 1 || overflow2 !== 1'b0) begin
            errors++;
            $display("FAIL t2_done_ovf: frame_done count %0d ovf=%b, required 1 and 0", fd2, overflow2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_hold();
        int g0, f0;
        g0 = got_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < FB; k++) fb[k] = 1'($urandom_range(0, 1));
        send_frame(FB, 4, FB, 1'b0);
        checks++;
        if (overflow !== 1'b1 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL t3_stalled: ovf=%b valid=%b, required 1 and 1", overflow, word_valid);
        end
        wait_drain("t3");
        checks++;
        if ((got_cnt - g0) != 4 || (fd_cnt - f0) != 0) begin
            errors++;
            $display("FAIL t3_counts: words %0d frame_done %0d, required 4 and 0",
                     got_cnt - g0, fd_cnt - f0);
        end
        do_reset();
    endtask

    task automatic test_full_push_pop();
        int g0;
        g0 = got_cnt;
        for (int k = 0; k < FB; k++) fb[k] = 1'((k % 5) == 0 || (k % 7) == 3);
        send_frame(FB, 18, 89, 1'b0);
        wait_drain("t4");
        checks++;
        if ((got_cnt - g0) != 18 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t4_counts: words %0d ovf=%b, required 18 and 0", got_cnt - g0, overflow);
        end
    endtask

    task automatic test_drain_overflow();
        int g0, f0;
        g0 = got_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < FB; k++) fb[k] = 1'((k % 3) == 0);
        send_frame(FB, 18, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            edge_in    = 1'b1;
            edge_valid = 1'b1;
            @(posedge clk); #1;
        end
        edge_valid = 1'b0;
        edge_in    = 1'b0;
        checks++;
        if (overflow !== 1'b1 || word_valid !== 1'b1 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL t5_drain_stall: ovf=%b valid=%b last=%b, required 1 1 1",
                     overflow, word_valid, word_last);
        end
        wait_drain("t5a");
        for (int k = 0; k < FB; k++) fb[k] = 1'($urandom_range(0, 1));
        send_frame(FB, 18, 0, 1'b0);
        wait_drain("t5b");
        checks++;
        if ((got_cnt - g0) != 36 || (fd_cnt - f0) != 2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL t5_counts: words %0d frame_done %0d ovf=%b, required 36 2 1",
                     got_cnt - g0, fd_cnt - f0, overflow);
        end
    endtask

    task automatic test_midframe_reset();
        int g0, f0;
        for (int k = 0; k < FB; k++) fb[k] = 1'($urandom_range(0, 1));
        send_frame(100, 18, 0, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL t6_prefix_words: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (word_valid !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_reset: valid=%b ovf=%b done=%b, required 0 0 0",
                     word_valid, overflow, frame_done);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        g0 = got_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < FB; k++) fb[k] = 1'($urandom_range(0, 1));
        send_frame(FB, 18, 0, 1'b0);
        wait_drain("t6");
        checks++;
        if ((got_cnt - g0) != 18 || (fd_cnt - f0) != 1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t6_counts: words %0d frame_done %0d ovf=%b, required 18 1 0",
                     got_cnt - g0, fd_cnt - f0, overflow);
        end
    endtask

    initial begin
        reset       = 1'b0;
        edge_in     = 1'b0;
        edge_valid  = 1'b0;
        word_ready  = 1'b0;
        edge_in2    = 1'b0;
        edge_valid2 = 1'b0;
        word_ready2 = 1'b0;
        test_reset();
        test_alternating();
        test_word16();
        test_overflow_hold();
        test_full_push_pop();
        test_drain_overflow();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
